// File: rtl/operand_fetch.sv
// Issue-side operand fetch with a RAW/WAW hazard scoreboard in front of a 32x32 register file.
// Writebacks pass straight through to the register file write port and retire scoreboard entries.
//
// state | meaning
// IDLE  | no bundle held; may accept an instruction
// FETCH | register file read in flight; capture operands this cycle
// VALID | bundle presented downstream; may accept when it is taken
module operand_fetch (
  input  logic        RegClk,
  input  logic        RegReset_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  InRs1,
  input  logic [4:0]  InRs2,
  input  logic [4:0]  InRd,
  input  logic        InRdEn,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutA,
  output logic [31:0] OutB,
  output logic [4:0]  OutRd,
  output logic        OutRdEn,
  input  logic        WbValid,
  input  logic [4:0]  WbRd,
  input  logic [31:0] WbData,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic        hold_rd_en_q, hold_rd_en_d;
  logic [31:0] out_a_q, out_a_d;
  logic [31:0] out_b_q, out_b_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_rd_en_q, out_rd_en_d;
  logic        out_valid_q, out_valid_d;

  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] pend_eff;
  logic        hazard;
  logic        can_accept;
  logic        accept;

  assign RegWrite      = WbValid & RegReset_n;
  assign WriteRegister = WbRd;
  assign WriteData     = WbData;

  // A writeback on this edge already clears its entry, so the dependent
  // instruction can issue and pick the value up through the register file bypass.
  always_comb begin
    clr_mask = '0;
    if (WbValid) clr_mask[WbRd] = 1'b1;
    pend_eff = pending_q & ~clr_mask;
    hazard   = pend_eff[InRs1] | pend_eff[InRs2] | (InRdEn & pend_eff[InRd]);
  end

  assign can_accept    = (state_q == ST_IDLE) | ((state_q == ST_VALID) & OutReady);
  assign InReady       = can_accept & ~hazard;
  assign accept        = InValid & InReady;
  assign ReadRegister1 = can_accept ? InRs1 : 5'd0;
  assign ReadRegister2 = can_accept ? InRs2 : 5'd0;

  always_comb begin
    set_mask = '0;
    if (accept && InRdEn && (InRd != 5'd0)) set_mask[InRd] = 1'b1;
    pending_d    = pend_eff | set_mask;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    hold_rd_d    = hold_rd_q;
    hold_rd_en_d = hold_rd_en_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_rd_d     = out_rd_q;
    out_rd_en_d  = out_rd_en_q;
    out_valid_d  = out_valid_q;

    if (accept) begin
      hold_rd_d    = InRd;
      hold_rd_en_d = InRdEn;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        out_a_d     = ReadData1;
        out_b_d     = ReadData2;
        out_rd_d    = hold_rd_q;
        out_rd_en_d = hold_rd_en_q;
        out_valid_d = 1'b1;
        state_d     = ST_VALID;
      end
      ST_VALID: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          state_d     = accept ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge RegClk or negedge RegReset_n) begin
    if (!RegReset_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      hold_rd_q    <= '0;
      hold_rd_en_q <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_rd_q     <= '0;
      out_rd_en_q  <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      hold_rd_q    <= hold_rd_d;
      hold_rd_en_q <= hold_rd_en_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_rd_q     <= out_rd_d;
      out_rd_en_q  <= out_rd_en_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign OutValid = out_valid_q;
  assign OutA     = out_a_q;
  assign OutB     = out_b_q;
  assign OutRd    = out_rd_q;
  assign OutRdEn  = out_rd_en_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file model
// (synchronous read, same-edge write bypass, r0 reads zero).
module tb_operand_fetch;

  logic        RegClk = 1'b0;
  logic        RegReset_n;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InRs1, InRs2, InRd;
  logic        InRdEn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutA, OutB;
  logic [4:0]  OutRd;
  logic        OutRdEn;
  logic        WbValid;
  logic [4:0]  WbRd;
  logic [31:0] WbData;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;

  int n_tests = 0;
  int n_fail  = 0;

  operand_fetch dut (
    .RegClk(RegClk), .RegReset_n(RegReset_n),
    .InValid(InValid), .InReady(InReady),
    .InRs1(InRs1), .InRs2(InRs2), .InRd(InRd), .InRdEn(InRdEn),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutA(OutA), .OutB(OutB), .OutRd(OutRd), .OutRdEn(OutRdEn),
    .WbValid(WbValid), .WbRd(WbRd), .WbData(WbData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
  );

  always #5 RegClk = ~RegClk;

  // Register file model: unwritten registers hold a fixed preload pattern.
  logic [31:0] mem [32];
  logic [31:0] written = '0;

  function automatic logic [31:0] init_val(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (r == 5'd3) return 32'h11;
    if (r == 5'd4) return 32'h22;
    return 32'h100 + {27'd0, r};
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (RegWrite && WriteRegister == r) return WriteData;
    if (written[r]) return mem[r];
    return init_val(r);
  endfunction

  always @(posedge RegClk) begin
    if (RegWrite && WriteRegister != 5'd0) begin
      mem[WriteRegister]     <= WriteData;
      written[WriteRegister] <= 1'b1;
    end
    ReadData1 <= rf_read(ReadRegister1);
    ReadData2 <= rf_read(ReadRegister2);
  end

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_en;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge RegClk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rd_en);
    InValid = v;
    InRs1   = rs1;
    InRs2   = rs2;
    InRd    = rd;
    InRdEn  = rd_en;
  endtask

  task automatic drain;
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
    WbValid = 1'b1;
    WbRd    = rd;
    WbData  = data;
    tick();
    WbValid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive_in(1'b1, v.rs1, v.rs2, v.rd, v.rd_en);
    #1;
    chk($sformatf("v%0d_in_ready", idx), {31'd0, InReady}, 32'd1);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk($sformatf("v%0d_fetch_not_valid", idx), {31'd0, OutValid}, 32'd0);
    tick();
    chk($sformatf("v%0d_out_valid", idx), {31'd0, OutValid}, 32'd1);
    chk($sformatf("v%0d_out_a", idx), OutA, v.exp_a);
    chk($sformatf("v%0d_out_b", idx), OutB, v.exp_b);
    chk($sformatf("v%0d_out_rd", idx), {27'd0, OutRd}, {27'd0, v.rd});
    chk($sformatf("v%0d_out_rd_en", idx), {31'd0, OutRdEn}, {31'd0, v.rd_en});
    drain();
    if (v.rd_en && v.rd != 5'd0) writeback(v.rd, 32'hC0DE_0000 | {27'd0, v.rd});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{rs1: 5'd3,  rs2: 5'd4,  rd: 5'd0,  rd_en: 1'b0, exp_a: 32'h11,        exp_b: 32'h22};
    vecs[1] = '{rs1: 5'd0,  rs2: 5'd31, rd: 5'd12, rd_en: 1'b1, exp_a: 32'h0,         exp_b: 32'h11F};
    vecs[2] = '{rs1: 5'd12, rs2: 5'd12, rd: 5'd0,  rd_en: 1'b1, exp_a: 32'hC0DE000C,  exp_b: 32'hC0DE000C};
    vecs[3] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd5,  rd_en: 1'b0, exp_a: 32'h0,         exp_b: 32'h0};
    vecs[4] = '{rs1: 5'd31, rs2: 5'd1,  rd: 5'd31, rd_en: 1'b1, exp_a: 32'h11F,       exp_b: 32'h101};
    vecs[5] = '{rs1: 5'd31, rs2: 5'd3,  rd: 5'd0,  rd_en: 1'b0, exp_a: 32'hC0DE001F,  exp_b: 32'h11};

    RegReset_n = 1'b0;
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    OutReady = 1'b0;
    WbValid  = 1'b1;
    WbRd     = 5'd3;
    WbData   = 32'hDEAD_BEEF;
    #2;
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_out_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_out_a", OutA, 32'h0);
    chk("rst_out_rd", {27'd0, OutRd}, 32'd0);
    chk("rst_in_ready", {31'd0, InReady}, 32'd1);
    WbValid = 1'b0;
    tick();
    tick();
    RegReset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // RAW: r5 pending until its writeback, which issues and bypasses on the same edge
    drive_in(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("raw_prod_a", OutA, 32'h101);
    drain();
    drive_in(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    chk("raw_stall0", {31'd0, InReady}, 32'd0);
    tick();
    chk("raw_stall1", {31'd0, InReady}, 32'd0);
    chk("raw_stall_no_out", {31'd0, OutValid}, 32'd0);
    WbValid = 1'b1;
    WbRd    = 5'd5;
    WbData  = 32'h0000_ABCD;
    #1;
    chk("raw_unblock", {31'd0, InReady}, 32'd1);
    chk("raw_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("raw_wr_reg", {27'd0, WriteRegister}, 32'd5);
    chk("raw_wr_data", WriteData, 32'h0000_ABCD);
    tick();
    WbValid = 1'b0;
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("raw_out_valid", {31'd0, OutValid}, 32'd1);
    chk("raw_bypass_a", OutA, 32'h0000_ABCD);
    drain();

    // WAW: r7 pending, second writer of r7 stalls until r7 retires, then re-marks it
    drive_in(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drain();
    drive_in(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    #1;
    chk("waw_stall", {31'd0, InReady}, 32'd0);
    WbValid = 1'b1;
    WbRd    = 5'd7;
    WbData  = 32'h77;
    #1;
    chk("waw_unblock", {31'd0, InReady}, 32'd1);
    tick();
    WbValid = 1'b0;
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("waw_out_rd", {27'd0, OutRd}, 32'd7);
    chk("waw_out_rd_en", {31'd0, OutRdEn}, 32'd1);
    drain();
    drive_in(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    chk("waw_still_pending", {31'd0, InReady}, 32'd0);
    WbValid = 1'b1;
    WbRd    = 5'd7;
    WbData  = 32'h7777;
    #1;
    chk("waw_release", {31'd0, InReady}, 32'd1);
    tick();
    WbValid = 1'b0;
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("waw_second_a", OutA, 32'h7777);
    drain();

    // Backpressure: bundle must hold for 5 cycles, queued instruction follows when taken
    drive_in(1'b1, 5'd3, 5'd4, 5'd8, 1'b0);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive_in(1'b1, 5'd4, 5'd3, 5'd9, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), {31'd0, OutValid}, 32'd1);
      chk($sformatf("bp%0d_a", c), OutA, 32'h11);
      chk($sformatf("bp%0d_b", c), OutB, 32'h22);
      chk($sformatf("bp%0d_rd", c), {27'd0, OutRd}, 32'd8);
      chk($sformatf("bp%0d_in_ready", c), {31'd0, InReady}, 32'd0);
      tick();
    end
    OutReady = 1'b1;
    #1;
    chk("bp_accept_ready", {31'd0, InReady}, 32'd1);
    tick();
    OutReady = 1'b0;
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("bp_next_fetch", {31'd0, OutValid}, 32'd0);
    tick();
    chk("bp_next_valid", {31'd0, OutValid}, 32'd1);
    chk("bp_next_a", OutA, 32'h22);
    chk("bp_next_b", OutB, 32'h11);
    chk("bp_next_rd", {27'd0, OutRd}, 32'd9);
    drain();

    // Reset during FETCH with r9 pending
    drive_in(1'b1, 5'd1, 5'd2, 5'd9, 1'b1);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    WbValid    = 1'b1;
    WbRd       = 5'd3;
    WbData     = 32'hDEAD_0003;
    RegReset_n = 1'b0;
    #1;
    chk("mid_rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("mid_rst_valid", {31'd0, OutValid}, 32'd0);
    tick();
    tick();
    chk("mid_rst_valid_held", {31'd0, OutValid}, 32'd0);
    chk("mid_rst_out_a", OutA, 32'h0);
    chk("mid_rst_out_rd_en", {31'd0, OutRdEn}, 32'd0);
    WbValid    = 1'b0;
    RegReset_n = 1'b1;
    drive_in(1'b1, 5'd9, 5'd3, 5'd0, 1'b0);
    #1;
    chk("post_rst_in_ready", {31'd0, InReady}, 32'd1);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("post_rst_valid", {31'd0, OutValid}, 32'd1);
    chk("post_rst_a", OutA, 32'h109);
    chk("post_rst_b_r3_untouched", OutB, 32'h11);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
